mem_port_arbiter: RTL and testbench

Shares one single-port 2048x32 SRAM (XSPRAMLP_2048X32_M8P, active-low CEn/WEn, 1-cycle registered read) between the pipeline's instruction-fetch port and its data-memory port, so the core can run from a unified memory macro. It sits between the PC/IF_ID stage, the EX_MEM/MEM_WB stage and the SRAM. It grants at most one access per cycle and generates per-port stall signals for the PC and hazard logic. It returns read data with a valid pulse and holds it stable for stalled consumers.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port 2048x32 SRAM (1-cycle registered read, active-low
//   CEn/WEn) between the instruction-fetch port and the data-memory port.
//   At most one access is granted per cycle. Data wins contention except
//   that fetch is forced a grant after MAX_DM_BURST consecutive contested
//   data grants. Responses arrive one cycle after the grant and are held
//   stable for stalled consumers.
//
// Ports
//   CLK, RST                  clock (rising edge), async active-low reset
//   IF_REQ/IF_ADDR            fetch request and byte address
//   IF_RDATA/IF_VALID         fetched word and its valid pulse
//   IF_STALL                  fetch request not granted this cycle
//   DM_REQ/DM_WE/DM_ADDR/DM_WDATA  data request, write flag, address, data
//   DM_RDATA/DM_VALID         read word and completion pulse
//   DM_STALL                  data request not granted this cycle
//   MEM_CEN/MEM_WEN/MEM_A/MEM_D   SRAM controls, word address, write data
//   MEM_Q                     SRAM read data (valid the cycle after a read)

module mem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int ADDR_W       = 11,
  parameter int MAX_DM_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IF_REQ,
  input  logic [WIDTH-1:0]  IF_ADDR,
  output logic [WIDTH-1:0]  IF_RDATA,
  output logic              IF_VALID,
  output logic              IF_STALL,
  input  logic              DM_REQ,
  input  logic              DM_WE,
  input  logic [WIDTH-1:0]  DM_ADDR,
  input  logic [WIDTH-1:0]  DM_WDATA,
  output logic [WIDTH-1:0]  DM_RDATA,
  output logic              DM_VALID,
  output logic              DM_STALL,
  output logic              MEM_CEN,
  output logic              MEM_WEN,
  output logic [ADDR_W-1:0] MEM_A,
  output logic [WIDTH-1:0]  MEM_D,
  input  logic [WIDTH-1:0]  MEM_Q
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_DM_BURST);

  // Owner of the access issued last cycle, i.e. who the MEM_Q/response
  // of this cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_DM_RD,
    OWN_DM_WR
  } owner_t;

  owner_t             owner_reg, owner_next;
  logic [3:0]         burst_cnt_reg, burst_cnt_next;
  logic [WIDTH-1:0]   if_hold_reg, dm_hold_reg;
  logic [ADDR_W-1:0]  a_last_reg;
  logic [WIDTH-1:0]   d_last_reg;

  logic               if_gnt, dm_gnt, any_gnt;
  logic [ADDR_W-1:0]  gnt_addr;

  // Byte offset and bits above the SRAM range are intentionally dropped
  // (addresses wrap modulo the SRAM size).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IF_ADDR[1:0], DM_ADDR[1:0],
                              IF_ADDR[WIDTH-1:ADDR_W+2], DM_ADDR[WIDTH-1:ADDR_W+2]};

  // Grant: same-cycle, forced off while reset is held.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (RST) begin
      if (IF_REQ && DM_REQ) begin
        if (burst_cnt_reg == BURST_MAX) if_gnt = 1'b1;
        else                            dm_gnt = 1'b1;
      end else begin
        if_gnt = IF_REQ;
        dm_gnt = DM_REQ;
      end
    end
  end

  assign any_gnt  = if_gnt | dm_gnt;
  assign IF_STALL = IF_REQ & ~if_gnt;
  assign DM_STALL = DM_REQ & ~dm_gnt;

  // Burst counter only advances on contested data grants; any cycle where
  // fetch is idle or wins resets the fairness window.
  always_comb begin
    burst_cnt_next = burst_cnt_reg;
    if (!IF_REQ || if_gnt)
      burst_cnt_next = 4'd0;
    else if (dm_gnt && burst_cnt_reg < BURST_MAX)
      burst_cnt_next = burst_cnt_reg + 4'd1;
  end

  // Owner next-state: records who issued this cycle's access.
  always_comb begin
    owner_next = OWN_NONE;
    if (if_gnt)      owner_next = OWN_IF;
    else if (dm_gnt) owner_next = DM_WE ? OWN_DM_WR : OWN_DM_RD;
  end

  // SRAM drive. Address/data hold their last values while idle so the
  // macro pins do not toggle.
  assign gnt_addr = if_gnt ? IF_ADDR[ADDR_W+1:2] : DM_ADDR[ADDR_W+1:2];
  assign MEM_CEN  = ~any_gnt;
  assign MEM_WEN  = ~(dm_gnt & DM_WE);
  assign MEM_A    = any_gnt ? gnt_addr : a_last_reg;
  assign MEM_D    = any_gnt ? DM_WDATA : d_last_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      owner_reg     <= OWN_NONE;
      burst_cnt_reg <= 4'd0;
      if_hold_reg   <= '0;
      dm_hold_reg   <= '0;
      a_last_reg    <= '0;
      d_last_reg    <= '0;
    end else begin
      owner_reg     <= owner_next;
      burst_cnt_reg <= burst_cnt_next;
      if (owner_reg == OWN_IF)    if_hold_reg <= MEM_Q;
      if (owner_reg == OWN_DM_RD) dm_hold_reg <= MEM_Q;
      if (any_gnt) begin
        a_last_reg <= gnt_addr;
        d_last_reg <= DM_WDATA;
      end
    end
  end

  // Response: live MEM_Q in the valid cycle, held copy otherwise.
  assign IF_VALID = (owner_reg == OWN_IF);
  assign DM_VALID = (owner_reg == OWN_DM_RD) || (owner_reg == OWN_DM_WR);
  assign IF_RDATA = (owner_reg == OWN_IF)    ? MEM_Q : if_hold_reg;
  assign DM_RDATA = (owner_reg == OWN_DM_RD) ? MEM_Q : dm_hold_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed steps followed by a randomized
// phase, all checked against a behavioural model of the arbiter and memory.
module tb_mem_port_arbiter;

  localparam int MAXB = 4;

  logic        CLK;
  logic        RST;
  logic        IF_REQ;
  logic [31:0] IF_ADDR;
  logic [31:0] IF_RDATA;
  logic        IF_VALID;
  logic        IF_STALL;
  logic        DM_REQ;
  logic        DM_WE;
  logic [31:0] DM_ADDR;
  logic [31:0] DM_WDATA;
  logic [31:0] DM_RDATA;
  logic        DM_VALID;
  logic        DM_STALL;
  logic        MEM_CEN;
  logic        MEM_WEN;
  logic [10:0] MEM_A;
  logic [31:0] MEM_D;
  logic [31:0] MEM_Q;

  mem_port_arbiter #(.WIDTH(32), .ADDR_W(11), .MAX_DM_BURST(MAXB)) dut (
    .CLK(CLK), .RST(RST),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA),
    .IF_VALID(IF_VALID), .IF_STALL(IF_STALL),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
    .DM_RDATA(DM_RDATA), .DM_VALID(DM_VALID), .DM_STALL(DM_STALL),
    .MEM_CEN(MEM_CEN), .MEM_WEN(MEM_WEN), .MEM_A(MEM_A), .MEM_D(MEM_D),
    .MEM_Q(MEM_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM macro stand-in: single port, registered read.
  logic [31:0] sram [0:2047];
  always @(posedge CLK) begin
    if (!MEM_CEN) begin
      if (!MEM_WEN) sram[MEM_A] <= MEM_D;
      else          MEM_Q <= sram[MEM_A];
    end
  end

  // Behavioural model state.
  logic [31:0] ref_mem [0:2047];
  int          burst_m;
  int          pend_kind;   // 0 none, 1 fetch, 2 data read, 3 data write
  logic [31:0] pend_data;
  logic [31:0] if_hold_m, dm_hold_m, last_a_m, last_d_m;
  logic        exp_if_stall, exp_dm_stall;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check every output against the model, then
  // advance the model and the clock.
  task automatic cycle(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic we, input logic [31:0] da,
                       input logic [31:0] wd);
    logic eg_if, eg_dm;
    int   word;
    RST = r; IF_REQ = ir; IF_ADDR = ia;
    DM_REQ = dr; DM_WE = we; DM_ADDR = da; DM_WDATA = wd;
    #1;
    if (!r) begin
      pend_kind = 0; burst_m = 0; if_hold_m = 0; dm_hold_m = 0;
      last_a_m = 0; last_d_m = 0;
    end
    chk("if_valid", 32'(IF_VALID), 32'(pend_kind == 1));
    chk("dm_valid", 32'(DM_VALID), 32'(pend_kind >= 2));
    chk("if_rdata", IF_RDATA, (pend_kind == 1) ? pend_data : if_hold_m);
    chk("dm_rdata", DM_RDATA, (pend_kind == 2) ? pend_data : dm_hold_m);

    eg_if = 1'b0; eg_dm = 1'b0;
    if (r) begin
      if (ir && dr) begin
        if (burst_m == MAXB) eg_if = 1'b1; else eg_dm = 1'b1;
      end else begin
        eg_if = ir; eg_dm = dr;
      end
    end
    exp_if_stall = ir & ~eg_if;
    exp_dm_stall = dr & ~eg_dm;
    word = int'(((eg_if ? ia : da) >> 2) % 2048);

    chk("if_stall", 32'(IF_STALL), 32'(exp_if_stall));
    chk("dm_stall", 32'(DM_STALL), 32'(exp_dm_stall));
    chk("mem_cen",  32'(MEM_CEN),  32'(!(eg_if || eg_dm)));
    chk("mem_wen",  32'(MEM_WEN),  32'(!(eg_dm && we)));
    chk("mem_a",    32'(MEM_A),    (eg_if || eg_dm) ? 32'(word) : last_a_m);
    chk("mem_d",    MEM_D,         (eg_if || eg_dm) ? wd : last_d_m);

    if (pend_kind == 1) if_hold_m = pend_data;
    if (pend_kind == 2) dm_hold_m = pend_data;
    if (eg_if) begin
      pend_kind = 1; pend_data = ref_mem[word];
    end else if (eg_dm && we) begin
      pend_kind = 3; ref_mem[word] = wd;
    end else if (eg_dm) begin
      pend_kind = 2; pend_data = ref_mem[word];
    end else begin
      pend_kind = 0;
    end
    if (!ir || eg_if) burst_m = 0;
    else if (eg_dm)   burst_m++;
    if (eg_if || eg_dm) begin
      last_a_m = 32'(word); last_d_m = wd;
    end
    @(posedge CLK); #1;
  endtask

  initial begin
    logic        ir, dr, we, r;
    logic [31:0] ia, da, wd;
    int          dm_grants;

    for (int i = 0; i < 2048; i++) begin
      sram[i]    = 32'hA5000000 ^ 32'(i * 7);
      ref_mem[i] = 32'hA5000000 ^ 32'(i * 7);
    end
    sram[0] = 32'h00000013;
    ref_mem[0] = 32'h00000013;
    MEM_Q = 32'h0;
    pend_kind = 0; burst_m = 0; pend_data = 0;
    if_hold_m = 0; dm_hold_m = 0; last_a_m = 0; last_d_m = 0;

    // Reset held with both ports requesting.
    cycle(0, 1, 32'h4, 1, 0, 32'h8, 32'h0);
    cycle(0, 1, 32'h4, 1, 0, 32'h8, 32'h0);
    chk("reset_if_rdata", IF_RDATA, 32'h0);

    // First fetch after release.
    cycle(1, 1, 32'h0, 0, 0, 32'h0, 32'h0);
    chk("first_fetch", IF_RDATA, 32'h00000013);

    // Back-to-back fetch.
    cycle(1, 1, 32'h0, 0, 0, 32'h0, 32'h0);
    cycle(1, 1, 32'h4, 0, 0, 32'h0, 32'h0);
    cycle(1, 1, 32'h8, 0, 0, 32'h0, 32'h0);
    chk("b2b_last_word", IF_RDATA, 32'hA5000000 ^ 32'd14);
    cycle(1, 0, 32'h8, 0, 0, 32'h0, 32'h0);

    // Contention: DM x4 then IF, repeating.
    dm_grants = 0;
    for (int k = 0; k < 15; k++) begin
      cycle(1, 1, 32'h40, 1, 0, 32'h80, 32'h0);
      chk("contention_if_grant", 32'(IF_VALID), 32'(k % 5 == 4));
      if (DM_VALID) dm_grants++;
    end
    chk("contention_dm_grants", 32'(dm_grants), 32'd12);
    cycle(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Write then read the same address.
    cycle(1, 0, 32'h0, 1, 1, 32'h100, 32'hDEADBEEF);
    chk("wr_valid", 32'(DM_VALID), 32'd1);
    cycle(1, 0, 32'h0, 1, 0, 32'h100, 32'h0);
    chk("rd_after_wr", DM_RDATA, 32'hDEADBEEF);

    // Hold on idle, then address wrap.
    cycle(1, 0, 32'h0, 1, 1, 32'h200, 32'h12345678);
    cycle(1, 1, 32'h200, 0, 0, 32'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 0, 32'h200, 0, 0, 32'h0, 32'h0);
      chk("hold_if_rdata", IF_RDATA, 32'h12345678);
    end
    cycle(1, 1, 32'h2001, 0, 0, 32'h0, 32'h0);
    chk("wrap_fetch", IF_RDATA, 32'h00000013);

    // Reset during an in-flight data read.
    cycle(1, 0, 32'h0, 1, 0, 32'h100, 32'h0);
    cycle(0, 0, 32'h0, 0, 0, 32'h100, 32'h0);
    cycle(0, 0, 32'h0, 0, 0, 32'h100, 32'h0);
    chk("reset_dm_rdata", DM_RDATA, 32'h0);
    cycle(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);

    // Randomized traffic; stalled fetch holds its request, stalled data
    // either holds or withdraws.
    ir = 0; ia = 0; dr = 0; we = 0; da = 0; wd = 0;
    exp_if_stall = 0; exp_dm_stall = 0;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 59) != 0);
      if (!(exp_if_stall && r)) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = (32'($urandom_range(0, 7)) << 13) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
      end
      if (exp_dm_stall && r && $urandom_range(0, 1) == 1) begin
        dr = 1'b1;
      end else begin
        dr = ($urandom_range(0, 2) != 0);
        we = $urandom_range(0, 1) == 1;
        da = (32'($urandom_range(0, 7)) << 13) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
        wd = $urandom;
      end
      cycle(r, ir, ia, dr, we, da, wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
